// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory port arbiter and its optional fetch line buffer.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    typedef logic [63:0] line_bus_t;

    localparam int TAG_W = 29;

    // A 32-bit store lands in the upper half of the line when addr[2] is 0.
    function automatic logic [7:0] store_strobe(input logic hi_word, input logic [3:0] be);
        return hi_word ? {4'h0, be} : {be, 4'h0};
    endfunction

endpackage

// File: rtl/mem_port_arbiter_fetch_line_buf.sv
// One-entry fetch line buffer: tag/valid/data with lookup, fill and store-driven invalidate.
module fetch_line_buf
    import mem_port_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             hit,
    output line_bus_t        line,
    input  logic             fill_en,
    input  logic [TAG_W-1:0] fill_tag,
    input  line_bus_t        fill_data,
    input  logic             inv_en,
    input  logic [TAG_W-1:0] inv_tag
);

    logic             valid_q, valid_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    line_bus_t        data_q, data_d;

    // Invalidate wins over fill; the arbiter never issues both in one cycle anyway.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (fill_en) begin
            valid_d = 1'b1;
            tag_d   = fill_tag;
            data_d  = fill_data;
        end
        if (inv_en && valid_q && (inv_tag == tag_q)) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            data_q  <= data_d;
        end
    end

    assign hit  = valid_q && (tag_q == lookup_tag);
    assign line = data_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit memory bus between instruction fetch and the LSU, one transaction at a time.
// Define FETCH_LINE_BUF_EN to add a one-entry fetch line buffer that serves repeat fetches off-bus.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output line_bus_t   if_rdata,
    output logic        if_rvalid,
    output logic        if_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_be,
    output logic [31:0] d_rdata,
    output logic        d_rvalid,
    output logic        d_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output line_bus_t   mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  line_bus_t   mem_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_e  state_q, state_d;
    owner_e      owner_q, owner_d;
    logic        drop_q, drop_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    line_bus_t   wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic        d_word_q, d_word_d;

    logic if_busy, d_busy, resp_valid, if_resp_ok, if_bus_req, lsu_win, if_win;
    logic unused_addr_bits;

    assign if_busy    = (state_q != ARB_IDLE) && (owner_q == OWN_IF);
    assign d_busy     = (state_q != ARB_IDLE) && (owner_q == OWN_D);
    assign resp_valid = mem_rvalid && (state_q != ARB_IDLE);
    assign if_resp_ok = resp_valid && (owner_q == OWN_IF) && !drop_q && !if_flush;

    // Arbitration happens only in IDLE; the bus request is latched so a redirect cannot disturb it.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        drop_d       = drop_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        d_word_d     = d_word_q;
        lsu_win      = 1'b0;
        if_win       = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                lsu_win = d_req && (!if_bus_req || (starve_cnt_q < STARVE_LIM));
                if_win  = !lsu_win && if_bus_req;
                if (lsu_win) begin
                    state_d  = ARB_REQ;
                    owner_d  = OWN_D;
                    addr_d   = {d_addr[31:3], 3'b000};
                    we_d     = d_we;
                    wdata_d  = {d_wdata, d_wdata};
                    wstrb_d  = store_strobe(d_addr[2], d_be);
                    d_word_d = d_addr[2];
                    if (if_bus_req && (starve_cnt_q != 4'hF)) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end else if (if_win) begin
                    state_d      = ARB_REQ;
                    owner_d      = OWN_IF;
                    addr_d       = {if_addr[31:3], 3'b000};
                    we_d         = 1'b0;
                    wdata_d      = '0;
                    wstrb_d      = 8'h00;
                    starve_cnt_d = 4'd0;
                end
            end
            ARB_REQ: begin
                if (mem_gnt) begin
                    state_d = mem_rvalid ? ARB_IDLE : ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (mem_rvalid) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
        if (if_flush && if_busy) begin
            drop_d = 1'b1;
        end
        if (state_d == ARB_IDLE) begin
            drop_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_IF;
            drop_q       <= 1'b0;
            starve_cnt_q <= 4'd0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            wstrb_q      <= 8'h00;
            d_word_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            drop_q       <= drop_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            d_word_q     <= d_word_d;
        end
    end

`ifdef FETCH_LINE_BUF_EN
    logic      hit_q, hit_d, buf_tag_hit, buf_hit_now;
    line_bus_t buf_line;

    fetch_line_buf u_line_buf (
        .clk        (clk),
        .rst        (rst),
        .lookup_tag (if_addr[31:3]),
        .hit        (buf_tag_hit),
        .line       (buf_line),
        .fill_en    (if_resp_ok),
        .fill_tag   (addr_q[31:3]),
        .fill_data  (mem_rdata),
        .inv_en     (lsu_win && d_we),
        .inv_tag    (d_addr[31:3])
    );

    // hit_q blocks a second lookup while the held if_req waits for its buffered response.
    always_comb begin
        buf_hit_now = if_req && buf_tag_hit && !if_busy && !hit_q;
        if_bus_req  = if_req && !buf_hit_now && !hit_q;
        hit_d       = buf_hit_now && !if_flush;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_q <= 1'b0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign if_rvalid = if_resp_ok || (hit_q && !if_flush);
    assign if_rdata  = hit_q ? buf_line : (if_busy ? mem_rdata : '0);
`else
    assign if_bus_req = if_req;
    assign if_rvalid  = if_resp_ok;
    assign if_rdata   = if_busy ? mem_rdata : '0;
`endif

    assign d_rvalid  = resp_valid && (owner_q == OWN_D);
    assign d_rdata   = d_busy ? (d_word_q ? mem_rdata[31:0] : mem_rdata[63:32]) : 32'h0;
    assign if_stall  = if_req && !if_rvalid;
    assign d_stall   = d_req && !d_rvalid;

    assign mem_req   = (state_q == ARB_REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;

    assign unused_addr_bits = ^{if_addr[2:0], d_addr[1:0]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: expected responses queue up as requests are driven.
module tb_mem_port_arbiter;

    logic        clk, rst;
    logic        if_req, if_flush, if_rvalid, if_stall;
    logic [31:0] if_addr;
    logic [63:0] if_rdata;
    logic        d_req, d_we, d_rvalid, d_stall;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr;
    logic [63:0] mem_wdata, mem_rdata;
    logic [7:0]  mem_wstrb;

    logic        bus_auto, man_gnt, man_rvalid;
    logic [63:0] auto_line, man_rdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        bit          is_if;
        logic [63:0] data;
        bit          chk;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        logic [7:0]  wstrb;
    } lsu_op_t;

    // Zero-wait bus grants and answers in the same cycle as mem_req; manual mode is cycle-scripted.
    assign mem_gnt    = bus_auto ? mem_req : man_gnt;
    assign mem_rvalid = bus_auto ? mem_req : man_rvalid;
    assign mem_rdata  = bus_auto ? auto_line : man_rdata;

    mem_port_arbiter #(.STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_rvalid(if_rvalid), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({mem_req, mem_we, if_rvalid, d_rvalid, if_stall, d_stall} !== 6'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got=%b exp=000000",
                     {mem_req, mem_we, if_rvalid, d_rvalid, if_stall, d_stall});
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wstrb !== 8'h0 || mem_wdata !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_bus got=%h/%h/%h exp=0", mem_addr, mem_wstrb, mem_wdata);
        end
        checks++;
        if (if_rdata !== 64'h0 || d_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_rdata got=%h/%h exp=0", if_rdata, d_rdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_if_fetch();
        exp_t e;
        bit   got = 1'b0;
        bus_auto  = 1'b1;
        auto_line = 64'h0123_4567_89AB_CDEF;
        step();
        if_req  = 1'b1;
        if_addr = 32'h104;
        exp_q.push_back('{is_if: 1'b1, data: auto_line, chk: 1'b1});
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (if_stall !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL if_stall_wait got=%b exp=1", if_stall);
                end
            end
            if (mem_req) begin
                checks++;
                if (mem_addr !== 32'h100) begin
                    errors++;
                    $display("[TB] FAIL if_mem_addr got=%h exp=00000100", mem_addr);
                end
            end
            if (if_rvalid) begin
                got = 1'b1;
                e = exp_q.pop_front();
                checks++;
                if (if_rdata !== e.data) begin
                    errors++;
                    $display("[TB] FAIL if_rdata got=%h exp=%h", if_rdata, e.data);
                end
                checks++;
                if (c - 1 != 1) begin
                    errors++;
                    $display("[TB] FAIL if_latency got=%0d exp=1", c - 1);
                end
                checks++;
                if (if_stall !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL if_stall_done got=%b exp=0", if_stall);
                end
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL if_timeout got=no_rvalid exp=rvalid");
        end
        step();
        if_req = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_lsu();
        lsu_op_t ops[4];
        exp_t    e;
        bit      got;
        ops[0] = '{we: 1'b0, addr: 32'h204, wdata: 32'h0, be: 4'h0, rdata: 32'h2222_2222, wstrb: 8'h00};
        ops[1] = '{we: 1'b0, addr: 32'h200, wdata: 32'h0, be: 4'h0, rdata: 32'h1111_1111, wstrb: 8'h00};
        ops[2] = '{we: 1'b1, addr: 32'h200, wdata: 32'hCAFE_F00D, be: 4'b0011, rdata: 32'h0, wstrb: 8'b0011_0000};
        ops[3] = '{we: 1'b1, addr: 32'h20C, wdata: 32'h1234_5678, be: 4'b1001, rdata: 32'h0, wstrb: 8'b0000_1001};
        bus_auto  = 1'b1;
        auto_line = 64'h1111_1111_2222_2222;
        for (int i = 0; i < 4; i++) begin
            step();
            d_req   = 1'b1;
            d_we    = ops[i].we;
            d_addr  = ops[i].addr;
            d_wdata = ops[i].wdata;
            d_be    = ops[i].be;
            exp_q.push_back('{is_if: 1'b0, data: {32'h0, ops[i].rdata}, chk: !ops[i].we});
            got = 1'b0;
            for (int c = 0; c < 8 && !got; c++) begin
                @(negedge clk);
                if (mem_req) begin
                    checks++;
                    if (mem_addr !== (ops[i].addr & 32'hFFFF_FFF8) || mem_we !== ops[i].we) begin
                        errors++;
                        $display("[TB] FAIL lsu_bus op%0d got=%h/%b exp=%h/%b", i, mem_addr, mem_we,
                                 ops[i].addr & 32'hFFFF_FFF8, ops[i].we);
                    end
                    if (ops[i].we) begin
                        checks++;
                        if (mem_wstrb !== ops[i].wstrb || mem_wdata !== {ops[i].wdata, ops[i].wdata}) begin
                            errors++;
                            $display("[TB] FAIL lsu_store op%0d got=%b/%h exp=%b/%h", i, mem_wstrb,
                                     mem_wdata, ops[i].wstrb, {ops[i].wdata, ops[i].wdata});
                        end
                    end
                end
                if (d_rvalid) begin
                    got = 1'b1;
                    e = exp_q.pop_front();
                    if (e.chk) begin
                        checks++;
                        if (d_rdata !== e.data[31:0]) begin
                            errors++;
                            $display("[TB] FAIL lsu_rdata op%0d got=%h exp=%h", i, d_rdata, e.data[31:0]);
                        end
                    end
                end
            end
            checks++;
            if (!got) begin
                errors++;
                $display("[TB] FAIL lsu_timeout op%0d got=no_rvalid exp=rvalid", i);
            end
            step();
            d_req = 1'b0;
            d_we  = 1'b0;
            exp_q.delete();
        end
    endtask

    task automatic test_starvation();
        exp_t e;
        int   n = 0;
        bus_auto  = 1'b1;
        auto_line = 64'hAAAA_0001_BBBB_0002;
        for (int r = 0; r < 10; r++) begin
            if (r % 5 == 4) exp_q.push_back('{is_if: 1'b1, data: auto_line, chk: 1'b1});
            else            exp_q.push_back('{is_if: 1'b0, data: {32'h0, auto_line[63:32]}, chk: 1'b1});
        end
        step();
        if_req = 1'b1;
        if_addr = 32'h400;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h300;
        for (int c = 0; c < 60 && n < 10; c++) begin
            @(negedge clk);
            if (if_rvalid || d_rvalid) begin
                n++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL starve_extra got=response exp=none");
                end else begin
                    e = exp_q.pop_front();
                    if (if_rvalid !== e.is_if || d_rvalid === e.is_if ||
                        (e.is_if ? if_rdata : {32'h0, d_rdata}) !== e.data) begin
                        errors++;
                        $display("[TB] FAIL starve_grant%0d got=if%b/d%b exp=if%b", n, if_rvalid,
                                 d_rvalid, e.is_if);
                    end
                end
            end
        end
        checks++;
        if (n != 10) begin
            errors++;
            $display("[TB] FAIL starve_count got=%0d exp=10", n);
        end
        step();
        if_req = 1'b0;
        d_req  = 1'b0;
        exp_q.delete();
        repeat (3) step();
    endtask

    task automatic test_flush();
        exp_t e;
        bus_auto = 1'b0;
        step();
        if_req  = 1'b1;
        if_addr = 32'h300;
        step();
        step();
        man_gnt = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
            errors++;
            $display("[TB] FAIL flush_req_held got=%b/%h exp=1/00000300", mem_req, mem_addr);
        end
        step();
        man_gnt  = 1'b0;
        if_flush = 1'b1;
        if_addr  = 32'h400;
        exp_q.push_back('{is_if: 1'b1, data: 64'h4444_0000_4444_0001, chk: 1'b1});
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || if_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_wait got=%b/%b exp=0/0", mem_req, if_rvalid);
        end
        step();
        if_flush   = 1'b0;
        man_rvalid = 1'b1;
        man_rdata  = 64'h3333_0000_3333_0001;
        @(negedge clk);
        checks++;
        if (if_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_drop got=%b exp=0", if_rvalid);
        end
        step();
        man_rvalid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_idle got=%b exp=0", mem_req);
        end
        step();
        man_gnt    = 1'b1;
        man_rvalid = 1'b1;
        man_rdata  = 64'h4444_0000_4444_0001;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h400) begin
            errors++;
            $display("[TB] FAIL flush_refetch got=%b/%h exp=1/00000400", mem_req, mem_addr);
        end
        checks++;
        if (!if_rvalid || exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL flush_refetch_rvalid got=%b exp=1", if_rvalid);
        end else begin
            e = exp_q.pop_front();
            if (if_rdata !== e.data) begin
                errors++;
                $display("[TB] FAIL flush_refetch_data got=%h exp=%h", if_rdata, e.data);
            end
        end
        step();
        man_gnt    = 1'b0;
        man_rvalid = 1'b0;
        if_req     = 1'b0;
        exp_q.delete();
        step();
    endtask

    task automatic test_reset_mid();
        bus_auto = 1'b0;
        step();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h208;
        step();
        man_gnt = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_req got=%b exp=1", mem_req);
        end
        step();
        man_gnt    = 1'b0;
        rst        = 1'b1;
        d_req      = 1'b0;
        man_rvalid = 1'b1;
        man_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        checks++;
        if ({mem_req, if_rvalid, d_rvalid, if_stall, d_stall} !== 5'b0 ||
            d_rdata !== 32'h0 || if_rdata !== 64'h0) begin
            errors++;
            $display("[TB] FAIL rstmid_async got=%b/%h/%h exp=0",
                     {mem_req, if_rvalid, d_rvalid, if_stall, d_stall}, d_rdata, if_rdata);
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, if_rvalid, d_rvalid} !== 3'b0 || d_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL rstmid_ignore got=%b/%h exp=0", {mem_req, if_rvalid, d_rvalid}, d_rdata);
        end
        step();
        man_rvalid = 1'b0;
    endtask

`ifdef FETCH_LINE_BUF_EN
    task automatic test_line_buf();
        bit got;
        int bus_cycles;
        int lat;
        bus_auto  = 1'b1;
        auto_line = 64'h5555_0000_6666_0000;
        for (int f = 0; f < 3; f++) begin
            if (f == 2) begin
                step();
                d_req  = 1'b1;
                d_we   = 1'b1;
                d_addr = 32'h104;
                d_be   = 4'hF;
                for (int c = 0; c < 8 && !d_rvalid; c++) @(negedge clk);
                step();
                d_req = 1'b0;
                d_we  = 1'b0;
            end
            step();
            if_req  = 1'b1;
            if_addr = 32'h100;
            got = 1'b0;
            bus_cycles = 0;
            lat = 0;
            for (int c = 1; c <= 8 && !got; c++) begin
                @(negedge clk);
                if (mem_req) bus_cycles++;
                if (if_rvalid) begin
                    got = 1'b1;
                    lat = c - 1;
                end
            end
            checks++;
            if (!got || lat != 1 || if_rdata !== auto_line || (bus_cycles == 0) !== (f == 1)) begin
                errors++;
                $display("[TB] FAIL linebuf_fetch%0d got=rv%b/lat%0d/bus%0d exp=rv1/lat1/bus%0d",
                         f, got, lat, bus_cycles, (f == 1) ? 0 : 1);
            end
            step();
            if_req = 1'b0;
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;
        bus_auto = 1'b0; man_gnt = 1'b0; man_rvalid = 1'b0; man_rdata = '0; auto_line = '0;
        test_reset();
        test_if_fetch();
        test_lsu();
        test_starvation();
        test_flush();
        test_reset_mid();
`ifdef FETCH_LINE_BUF_EN
        test_line_buf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
